// File: rtl/maze_pkg.sv
// Shared maze definitions: grid size, tile codes, and the state and direction
// encodings used by the maze-side controllers.
package maze_pkg;

    localparam int MAZEX = 25;
    localparam int MAZEY = 17;

    localparam logic [3:0] TILE_EMPTY = 4'd0;
    localparam logic [3:0] TILE_HARD  = 4'd1;
    localparam logic [3:0] TILE_BRICK = 4'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EV,
        WR,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_XP,
        DIR_XN,
        DIR_YP,
        DIR_YN
    } dir_t;

endpackage

// File: rtl/maze_cell_step.sv
// Target cell of a move of 'step' cells from (x, y) in direction 'dir', and
// whether that cell lies inside the maze.
module maze_cell_step #(
    parameter int MAZEX = maze_pkg::MAZEX,
    parameter int MAZEY = maze_pkg::MAZEY
) (
    input  logic [4:0]     x_i,
    input  logic [4:0]     y_i,
    input  maze_pkg::dir_t dir_i,
    input  logic [2:0]     step_i,
    output logic [4:0]     tx_o,
    output logic [4:0]     ty_o,
    output logic           in_bounds_o
);
    import maze_pkg::*;

    localparam logic signed [5:0] XMAX = 6'(MAZEX - 1);
    localparam logic signed [5:0] YMAX = 6'(MAZEY - 1);

    logic signed [5:0] sx;
    logic signed [5:0] sy;
    logic signed [5:0] ds;

    // Six signed bits are enough: a step past either edge goes negative or
    // beyond the maximum index, never wraps back into range for valid cells.
    always_comb begin
        sx = $signed({1'b0, x_i});
        sy = $signed({1'b0, y_i});
        ds = $signed({3'b000, step_i});
        case (dir_i)
            DIR_XP:  sx = sx + ds;
            DIR_XN:  sx = sx - ds;
            DIR_YP:  sy = sy + ds;
            default: sy = sy - ds;
        endcase
    end

    assign tx_o        = sx[4:0];
    assign ty_o        = sy[4:0];
    assign in_bounds_o = !sx[5] && !sy[5] && (sx <= XMAX) && (sy <= YMAX);

endmodule

// File: rtl/bomb_blast_ctrl.sv
// Bomb blast controller: walks the four flame arms of one explosion through the
// maze tile RAM, erasing bricks and stopping at walls, bricks and the maze edge.
module bomb_blast_ctrl #(
    parameter int MAZEX = maze_pkg::MAZEX,
    parameter int MAZEY = maze_pkg::MAZEY
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       active,
    input  logic       blast_req,
    input  logic [4:0] blast_x,
    input  logic [4:0] blast_y,
    input  logic [2:0] blast_range,
    output logic [9:0] ram_raddr,
    input  logic [3:0] ram_rdata,
    output logic [9:0] ram_waddr,
    output logic [3:0] ram_wdata,
    output logic       ram_we,
    output logic       busy,
    output logic       done,
    output logic [2:0] bricks
);
    import maze_pkg::*;

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [4:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic [2:0] range_q, range_d;
    logic [2:0] step_q, step_d;
    logic [2:0] bricks_q, bricks_d;
    logic [9:0] raddr_q, raddr_d;
    logic [9:0] waddr_q;
    logic       we_q, busy_q, done_q;

    logic       accept;
    logic       end_arm;
    logic [3:0] step_nxt;
    logic [4:0] cont_tx, cont_ty;
    logic       cont_ok;
    logic [4:0] arm_tx [4];
    logic [4:0] arm_ty [4];
    logic [3:0] arm_ok;
    logic [2:0] arm_from;
    logic       arm_found;
    dir_t       arm_dir;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        accept  = (state_q == IDLE) && blast_req;
        x_d     = accept ? blast_x : x_q;
        y_d     = accept ? blast_y : y_q;
        range_d = accept ? blast_range : range_q;
    end

    assign step_nxt = {1'b0, step_q} + 4'd1;

    // First cell of every arm, evaluated against the bomb cell of this blast
    // (the incoming request while IDLE) so out-of-bounds arms cost no cycles.
    for (genvar d = 0; d < 4; d++) begin : g_arm
        maze_cell_step #(.MAZEX(MAZEX), .MAZEY(MAZEY)) u_arm (
            .x_i         (x_d),
            .y_i         (y_d),
            .dir_i       (dir_t'(2'(d))),
            .step_i      (3'd1),
            .tx_o        (arm_tx[d]),
            .ty_o        (arm_ty[d]),
            .in_bounds_o (arm_ok[d])
        );
    end

    maze_cell_step #(.MAZEX(MAZEX), .MAZEY(MAZEY)) u_cont (
        .x_i         (x_q),
        .y_i         (y_q),
        .dir_i       (dir_q),
        .step_i      (step_nxt[2:0]),
        .tx_o        (cont_tx),
        .ty_o        (cont_ty),
        .in_bounds_o (cont_ok)
    );

    always_comb begin
        arm_from  = (state_q == IDLE) ? 3'd0 : ({1'b0, dir_q} + 3'd1);
        arm_found = 1'b0;
        arm_dir   = DIR_XP;
        for (int i = 3; i >= 0; i--) begin
            if (arm_ok[i] && (3'(i) >= arm_from)) begin
                arm_found = 1'b1;
                arm_dir   = dir_t'(i[1:0]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        step_d   = step_q;
        bricks_d = bricks_q;
        raddr_d  = raddr_q;
        end_arm  = 1'b0;
        case (state_q)
            IDLE: begin
                if (blast_req) begin
                    bricks_d = '0;
                    dir_d    = DIR_XP;
                    step_d   = 3'd1;
                    if (blast_range == 3'd0) state_d = DONE;
                    else                     end_arm = 1'b1;
                end
            end
            RD: begin
                if (!active) state_d = EV;
            end
            EV: begin
                if (ram_rdata == TILE_HARD) begin
                    end_arm = 1'b1;
                end else if (ram_rdata == TILE_BRICK) begin
                    state_d = WR;
                end else if ((step_nxt > {1'b0, range_q}) || !cont_ok) begin
                    end_arm = 1'b1;
                end else begin
                    step_d  = step_nxt[2:0];
                    raddr_d = {cont_ty, cont_tx};
                    state_d = RD;
                end
            end
            WR: begin
                bricks_d = bricks_q + 3'd1;
                end_arm  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Leaving an arm (or starting the first) jumps straight to the next
        // in-bounds arm; with none left the blast is finished.
        if (end_arm) begin
            step_d = 3'd1;
            if (arm_found) begin
                dir_d   = arm_dir;
                raddr_d = {arm_ty[arm_dir], arm_tx[arm_dir]};
                state_d = RD;
            end else begin
                state_d = DONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= DIR_XP;
            x_q      <= '0;
            y_q      <= '0;
            range_q  <= '0;
            step_q   <= '0;
            bricks_q <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            range_q  <= range_d;
            step_q   <= step_d;
            bricks_q <= bricks_d;
            raddr_q  <= raddr_d;
            // The cell being evaluated is still on the read address in EV.
            if (state_d == WR) waddr_q <= raddr_q;
            we_q     <= (state_d == WR);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    assign ram_raddr = raddr_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = TILE_EMPTY;
    assign ram_we    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bricks    = bricks_q;

endmodule

// File: tb/tb_bomb_blast_ctrl.sv
// Directed bench for bomb_blast_ctrl: a tile RAM model plus read/write
// scoreboards filled before each blast and drained by a bus monitor.
module tb_bomb_blast_ctrl;
    import maze_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       active;
    logic       blast_req;
    logic [4:0] blast_x, blast_y;
    logic [2:0] blast_range;
    logic [9:0] ram_raddr;
    logic [3:0] ram_rdata;
    logic [9:0] ram_waddr;
    logic [3:0] ram_wdata;
    logic       ram_we;
    logic       busy;
    logic       done;
    logic [2:0] bricks;

    logic [3:0] mem [0:1023];
    logic       mem_clr = 1'b0;
    logic       poke_en = 1'b0;
    logic [9:0] poke_addr = '0;
    logic [3:0] poke_data = '0;

    logic [9:0]  exp_rd [$];
    logic [13:0] exp_wr [$];

    int checks = 0;
    int errors = 0;

    bomb_blast_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .active      (active),
        .blast_req   (blast_req),
        .blast_x     (blast_x),
        .blast_y     (blast_y),
        .blast_range (blast_range),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .busy        (busy),
        .done        (done),
        .bricks      (bricks)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronous tile RAM: read data registered only while active is low.
    initial begin
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_clr) begin
                for (int i = 0; i < 1024; i++) mem[i] <= TILE_EMPTY;
            end else if (poke_en) begin
                mem[poke_addr] <= poke_data;
            end
            if (ram_we) mem[ram_waddr] <= ram_wdata;
            if (!active) ram_rdata <= mem[ram_raddr];
        end
    end

    // Bus monitor: each new read address while busy is one cell visit.
    initial begin
        logic [10:0] last_ra;
        int          sz;
        last_ra = 11'h7ff;
        forever begin
            @(negedge clk);
            if (!busy) begin
                last_ra = 11'h7ff;
            end else if ({1'b0, ram_raddr} != last_ra) begin
                last_ra = {1'b0, ram_raddr};
                sz = exp_rd.size();
                check("rd_pending", 32'(sz != 0), 32'd1);
                if (sz != 0) check("rd_addr", 32'(ram_raddr), 32'(exp_rd.pop_front()));
            end
            if (ram_we) begin
                sz = exp_wr.size();
                check("wr_pending", 32'(sz != 0), 32'd1);
                if (sz != 0) check("wr_addr_data", 32'({ram_waddr, ram_wdata}), 32'(exp_wr.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    function automatic void push_rd(input int x, input int y);
        exp_rd.push_back({5'(y), 5'(x)});
    endfunction

    function automatic void push_wr(input int x, input int y);
        exp_wr.push_back({5'(y), 5'(x), TILE_EMPTY});
    endfunction

    task automatic clear_mem();
        mem_clr = 1'b1;
        @(posedge clk); #1;
        mem_clr = 1'b0;
    endtask

    task automatic set_tile(input int x, input int y, input logic [3:0] t);
        poke_addr = {5'(y), 5'(x)};
        poke_data = t;
        poke_en   = 1'b1;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    // Entered just after a rising edge. Cycle 1 is the request cycle; the
    // cycle in which done is seen is reported as the latency.
    task automatic run_blast(input int bx, input int by, input int br, input int exp_cyc,
                             input int exp_bricks, input int stall_end, input int ign_at);
        int         n;
        logic       seen;
        logic [9:0] first_ra;
        n        = 0;
        seen     = 1'b0;
        first_ra = (exp_rd.size() > 0) ? exp_rd[0] : '0;
        blast_x     = 5'(bx);
        blast_y     = 5'(by);
        blast_range = 3'(br);
        blast_req   = 1'b1;
        active      = (stall_end > 0);
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            check("busy", 32'(busy), 32'(n >= 2));
            if (done) seen = 1'b1;
            else if (n >= 2 && n <= stall_end) check("stall_raddr", 32'(ram_raddr), 32'(first_ra));
            @(posedge clk); #1;
            blast_req = 1'b0;
            if (n == stall_end) active = 1'b0;
            if (n == ign_at) begin
                blast_x     = 5'd1;
                blast_y     = 5'd1;
                blast_range = 3'd7;
                blast_req   = 1'b1;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(exp_cyc));
        check("bricks", 32'(bricks), 32'(exp_bricks));
        check("rd_left", 32'(exp_rd.size()), 32'd0);
        check("wr_left", 32'(exp_wr.size()), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        active      = 1'b0;
        blast_req   = 1'b0;
        blast_x     = '0;
        blast_y     = '0;
        blast_range = '0;
        @(posedge clk); #1;
        clear_mem();
        @(negedge clk);
        check("rst_raddr", 32'(ram_raddr), 32'd0);
        check("rst_waddr", 32'(ram_waddr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bricks", 32'(bricks), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // (5,5) range 1, open field
        clear_mem();
        push_rd(6, 5); push_rd(4, 5); push_rd(5, 6); push_rd(5, 4);
        run_blast(5, 5, 1, 10, 0, 0, 0);

        // (5,5) range 3, brick at (7,5), wall at (5,4), passable code at (3,5)
        clear_mem();
        set_tile(7, 5, TILE_BRICK);
        set_tile(5, 4, TILE_HARD);
        set_tile(3, 5, 4'd5);
        push_rd(6, 5); push_rd(7, 5); push_wr(7, 5);
        push_rd(4, 5); push_rd(3, 5); push_rd(2, 5);
        push_rd(5, 6); push_rd(5, 7); push_rd(5, 8);
        push_rd(5, 4);
        run_blast(5, 5, 3, 21, 1, 0, 0);
        check("passable_kept", 32'(mem[{5'd5, 5'd3}]), 32'd5);
        check("brick_erased", 32'(mem[{5'd5, 5'd7}]), 32'(TILE_EMPTY));

        // corner (0,0): -X and -Y arms leave the maze immediately
        clear_mem();
        push_rd(1, 0); push_rd(2, 0); push_rd(0, 1); push_rd(0, 2);
        run_blast(0, 0, 2, 10, 0, 0, 0);

        // corner (24,16) range 7: +X and +Y skipped, two bricks
        clear_mem();
        set_tile(23, 16, TILE_BRICK);
        set_tile(24, 15, TILE_BRICK);
        push_rd(23, 16); push_wr(23, 16);
        push_rd(24, 15); push_wr(24, 15);
        run_blast(24, 16, 7, 8, 2, 0, 0);

        // active held high for the first five RD cycles of (11,8)
        clear_mem();
        set_tile(11, 8, TILE_BRICK);
        push_rd(11, 8); push_wr(11, 8);
        push_rd(9, 8); push_rd(10, 9); push_rd(10, 7);
        run_blast(10, 8, 1, 16, 1, 6, 0);

        // request while busy is ignored
        clear_mem();
        push_rd(6, 5); push_rd(4, 5); push_rd(5, 6); push_rd(5, 4);
        run_blast(5, 5, 1, 10, 0, 0, 3);

        // reset asserted during the write cycle of a brick at (6,5)
        clear_mem();
        set_tile(6, 5, TILE_BRICK);
        push_rd(6, 5); push_wr(6, 5);
        blast_x     = 5'd5;
        blast_y     = 5'd5;
        blast_range = 3'd3;
        blast_req   = 1'b1;
        @(posedge clk); #1;
        blast_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #2;
        check("wr_in_flight", 32'(ram_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("dropped_write", 32'(mem[{5'd5, 5'd6}]), 32'(TILE_BRICK));
        check("abort_rd_left", 32'(exp_rd.size()), 32'd0);
        check("abort_wr_left", 32'(exp_wr.size()), 32'd0);
        @(posedge clk); #1;

        push_rd(6, 5); push_wr(6, 5);
        push_rd(4, 5); push_rd(5, 6); push_rd(5, 4);
        run_blast(5, 5, 1, 11, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bomb_blast_ctrl.md
Name: bomb_blast_ctrl

Overview:
- Controller on the write/read side of the maze tile RAM; resolves one bomb explosion per request.
- Walks the four arms of the blast cell by cell:
  - destroys bricks by overwriting them with empty;
  - stops an arm at hard walls, bricks or the maze edge.
- Accesses the RAM only through the controller interface (ram_raddr/ram_rdata/ram_waddr/ram_wdata/ram_we).
- Issues reads only while active is low, so display reads are never disturbed.

Parameters:
- MAZEX, 25, maze width in cells (x valid 0..24)
- MAZEY, 17, maze height in cells (y valid 0..16)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- active  in  1  display active; RAM read port belongs to the display while high
- blast_req  in  1  one-cycle request; sampled only in IDLE
- blast_x  in  5  bomb cell x
- blast_y  in  5  bomb cell y
- blast_range  in  3  arm length in cells, 0..7
- ram_raddr  out  10  read address {y[4:0], x[4:0]}
- ram_rdata  in  4  tile code, valid one cycle after address is presented with active low
- ram_waddr  out  10  write address {y, x}
- ram_wdata  out  4  write data
- ram_we  out  1  write enable
- busy  out  1  high from the cycle after request acceptance until DONE inclusive
- done  out  1  one-cycle pulse at end of blast
- bricks  out  3  bricks destroyed by last blast (0..4); held until next acceptance

Behaviour:
- Reset values (async, reset_n low):
  - state=IDLE;
  - all outputs 0: ram_raddr, ram_waddr, ram_wdata, ram_we, busy, done, bricks.
- Tile codes: 0 empty, 1 hard wall, 2 brick. Codes 3..15 are passable (flame continues, tile unchanged).
- IDLE:
  - blast_req=1 latches x, y and range, clears the bricks counter, sets arm=+X, step=1.
  - Next state is RD, or DONE if range=0.
  - A blast_req while not IDLE is ignored (no queueing).
- Arm order: +X, -X, +Y, -Y. Cell = bomb cell + step*direction. The centre cell is never read or written.
- Arm advance:
  - Target out of bounds (x<0, x>MAZEX-1, y<0, y>MAZEY-1; computed in 6-bit signed): no RAM access, next arm.
  - No arm left: go to DONE.
- RD:
  - ram_raddr={ty,tx} driven every cycle.
  - If active=0 this cycle: go to EV. Else stay in RD (stall, no timeout).
- EV (samples ram_rdata, independent of active):
  - hard wall: end arm;
  - brick: go to WR;
  - otherwise: step+1. If step > range, end arm; else go to RD.
- WR:
  - ram_we=1 for exactly one cycle, ram_waddr={ty,tx}, ram_wdata=0.
  - bricks+1, then end arm.
  - Writes are not gated by active.
- DONE: done=1 for one cycle, busy=1, then IDLE. bricks is final and valid at done.
- Latency with active held low:
  - 2 cycles per non-brick cell, 3 per brick cell, 0 per out-of-bounds arm;
  - +1 acceptance cycle and +1 DONE cycle.
- Reset mid-blast aborts immediately. A write in flight is dropped; already-written bricks stay destroyed.
- ram_we is never high outside WR. ram_raddr is don't-care outside RD, but must stay registered (glitch-free).

Decomposition:
- Shared package maze_pkg:
  - tile constants TILE_EMPTY=0, TILE_HARD=1, TILE_BRICK=2;
  - MAZEX and MAZEY;
  - state enum (IDLE, RD, EV, WR, DONE);
  - direction enum (DIR_XP, DIR_XN, DIR_YP, DIR_YN).
- One sub-module, maze_cell_step: combinational target-cell and in-bounds computation from (x, y, dir, step). Reused later by player-movement collision logic.

Test Plan:
- Bomb (5,5), range 1, four empty neighbours, active=0 constant -> reads at 6,5 / 4,5 / 5,6 / 5,4 in order; no ram_we; done exactly 10 cycles after blast_req; bricks=0.
- Bomb (5,5), range 3, brick at (7,5), hard wall at (5,4), empty elsewhere:
  - single write: addr {5,7}, data 0;
  - no read of (8,5), (5,3) or (5,2);
  - bricks=1.
- Bomb (0,0), range 2, all empty -> -X and -Y arms make no RAM access; only (1,0), (2,0), (0,1), (0,2) read; done after 10 cycles.
- Bomb (24,16), range 7, bricks at (23,16) and (24,15) -> two writes, bricks=2. Also check +X and +Y are skipped at the maze edge.
- active toggling 1 for 5 cycles then 0, during RD -> FSM holds RD with address stable; proceeds on the first active=0 cycle; evaluated tile matches RAM contents.
- blast_req during busy -> ignored.
- reset_n pulsed low mid-arm -> busy=0, ram_we=0 immediately; next request runs normally.
